// File: rtl/tdm_demux.sv
// TDM receive demux: steers each valid word of a framed stream to its slot's channel register.
// One register stage from accepted word to ch_data/ch_valid; no backpressure, every valid word is consumed or discarded.
module tdm_demux #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SLOT_W = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        din,
   input  logic                    din_valid,
   input  logic                    sync_in,
   output logic [NUM_CH*WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]       ch_valid,
   output logic                    frame_done,
   output logic                    locked,
   output logic                    sync_err,
   output logic [SLOT_W-1:0]       slot
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t            state, state_nxt;
   logic [SLOT_W-1:0] slot_nxt;
   logic              wr_en;
   logic [SLOT_W-1:0] wr_ch;
   logic              done_nxt;
   logic              err_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= HUNT;
         slot  <= '0;
      end else begin
         state <= state_nxt;
         slot  <= slot_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      wr_en     = 1'b0;
      wr_ch     = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (din_valid) begin
         case (state)
            HUNT: begin
               if (sync_in) begin
                  wr_en     = 1'b1;
                  slot_nxt  = SLOT_ONE;
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (sync_in) begin
                  // Early sync restarts the frame; the partial frame gets no frame_done.
                  err_nxt  = (slot != '0);
                  wr_en    = 1'b1;
                  slot_nxt = SLOT_ONE;
               end else if (slot == '0) begin
                  err_nxt   = 1'b1;
                  state_nxt = HUNT;
               end else begin
                  wr_en = 1'b1;
                  wr_ch = slot;
                  if (slot == LAST_SLOT) begin
                     done_nxt = 1'b1;
                     slot_nxt = '0;
                  end else begin
                     slot_nxt = slot + SLOT_ONE;
                  end
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch_data    <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         frame_done <= done_nxt;
         sync_err   <= err_nxt;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_valid[i] <= wr_en && (wr_ch == SLOT_W'(i));
            if (wr_en && (wr_ch == SLOT_W'(i)))
               ch_data[i*WIDTH +: WIDTH] <= din;
         end
      end
   end

   assign locked = (state == LOCKED);

endmodule
